// File: rtl/banco_registros_sb.sv
// Pipeline register file: two combinational read ports, WB and late-load write
// ports, and a per-register busy scoreboard. Optional write-through: RF_BYPASS_EN.
module banco_registros_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [ADDR_W:0]   busy_count,
  output logic              wr_conflict
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [ADDR_W:0]   busy_count_q, busy_count_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic              wb_we, ld_we;

  assign wb_we         = wb_en && (wb_addr != '0);
  assign ld_we         = ld_en && (ld_addr != '0);
  assign wr_conflict_d = wb_we && ld_we && (wb_addr == ld_addr);

  // Writes clear busy first, then a same-cycle claim re-marks the register.
  always_comb begin
    busy_d = busy_q;
    if (wb_we)    busy_d[wb_addr]    = 1'b0;
    if (ld_we)    busy_d[ld_addr]    = 1'b0;
    if (claim_en) busy_d[claim_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    busy_count_d = '0;
    for (int unsigned i = 1; i < NREG; i++)
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q        <= '0;
      busy_count_q  <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      if (ld_we && !wr_conflict_d) regs_q[ld_addr] <= ld_data;
      if (wb_we)                   regs_q[wb_addr] <= wb_data;
      busy_q        <= busy_d;
      busy_count_q  <= busy_count_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_busy_a = busy_q[rd_addr_a];
`ifdef RF_BYPASS_EN
    if (wb_we && (wb_addr == rd_addr_a)) begin
      rd_data_a = wb_data;
      rd_busy_a = claim_en && (claim_addr == rd_addr_a);
    end else if (ld_we && (ld_addr == rd_addr_a)) begin
      rd_data_a = ld_data;
      rd_busy_a = claim_en && (claim_addr == rd_addr_a);
    end
`endif
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
      rd_busy_a = 1'b0;
    end
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    rd_busy_b = busy_q[rd_addr_b];
`ifdef RF_BYPASS_EN
    if (wb_we && (wb_addr == rd_addr_b)) begin
      rd_data_b = wb_data;
      rd_busy_b = claim_en && (claim_addr == rd_addr_b);
    end else if (ld_we && (ld_addr == rd_addr_b)) begin
      rd_data_b = ld_data;
      rd_busy_b = claim_en && (claim_addr == rd_addr_b);
    end
`endif
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
      rd_busy_b = 1'b0;
    end
  end

  assign stall       = rd_busy_a | rd_busy_b;
  assign busy_count  = busy_count_q;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_banco_registros_sb.sv
// Scoreboard bench for banco_registros_sb: reference model pushes expectations,
// DUT outputs are popped and compared. Honours RF_BYPASS_EN when defined.
module tb_banco_registros_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wb_addr, ld_addr, claim_addr;
  logic [DW-1:0] rd_data_a, rd_data_b, wb_data, ld_data;
  logic          rd_busy_a, rd_busy_b, stall, wb_en, ld_en, claim_en, wr_conflict;
  logic [AW:0]   busy_count;

  banco_registros_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b), .stall(stall),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .busy_count(busy_count), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [DW-1:0] m_reg  [NR];
  logic          m_busy [NR];
  logic [AW:0]   m_count;
  logic          m_conf;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb_q.push_back('{tag, v});
  endtask

  task automatic sb_pop(input logic [63:0] obs);
    sb_t e;
    if (sb_q.size() == 0) check_eq("sb_underflow", 64'd1, 64'd0);
    else begin
      e = sb_q.pop_front();
      check_eq(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_count = '0;
    m_conf  = 1'b0;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
    if (ld_en && ld_addr == a) return ld_data;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((wb_en && wb_addr == a) || (ld_en && ld_addr == a))
      return claim_en && (claim_addr == a);
`endif
    return m_busy[a];
  endfunction

  task automatic model_edge();
    logic wbw, ldw;
    int   cnt;
    wbw = wb_en && (wb_addr != 0);
    ldw = ld_en && (ld_addr != 0);
    m_conf = wbw && ldw && (wb_addr == ld_addr);
    if (ldw) begin m_reg[ld_addr] = ld_data; m_busy[ld_addr] = 1'b0; end
    if (wbw) begin m_reg[wb_addr] = wb_data; m_busy[wb_addr] = 1'b0; end
    if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
    cnt = 0;
    for (int i = 0; i < NR; i++) if (m_busy[i]) cnt++;
    m_count = cnt[AW:0];
  endtask

  // One cycle: check combinational reads, clock, then check registered outputs.
  task automatic step();
    logic ea, eb;
    #1;
    ea = exp_busy(rd_addr_a);
    eb = exp_busy(rd_addr_b);
    sb_push("rd_data_a", 64'(exp_data(rd_addr_a)));
    sb_push("rd_data_b", 64'(exp_data(rd_addr_b)));
    sb_push("rd_busy_a", 64'(ea));
    sb_push("rd_busy_b", 64'(eb));
    sb_push("stall",     64'(ea | eb));
    sb_pop(64'(rd_data_a));
    sb_pop(64'(rd_data_b));
    sb_pop(64'(rd_busy_a));
    sb_pop(64'(rd_busy_b));
    sb_pop(64'(stall));
    @(posedge clk);
    model_edge();
    #1;
    sb_push("busy_count",  64'(m_count));
    sb_push("wr_conflict", 64'(m_conf));
    sb_pop(64'(busy_count));
    sb_pop(64'(wr_conflict));
  endtask

  task automatic idle();
    wb_en = 0; ld_en = 0; claim_en = 0;
    wb_addr = 0; ld_addr = 0; claim_addr = 0;
    wb_data = 0; ld_data = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle();
    rd_addr_a = 0; rd_addr_b = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NR; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(i) ^ 5'h1f;
      step();
    end

    wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; rd_addr_a = 5; rd_addr_b = 0;
    step();
    idle(); rd_addr_a = 5;
    step();
    check_eq("reg5_value", 64'(rd_data_a), 64'hDEADBEEF);

    wb_en = 1; wb_addr = 0; wb_data = 32'h1; rd_addr_a = 0;
    step();
    idle(); rd_addr_a = 0;
    step();

    claim_en = 1; claim_addr = 7;
    step();
    idle(); rd_addr_a = 7;
    step();
    check_eq("claim7_stall", 64'(stall), 64'd1);
    check_eq("claim7_count", 64'(busy_count), 64'd1);
    ld_en = 1; ld_addr = 7; ld_data = 32'h55;
    step();
    idle(); rd_addr_a = 7;
    step();
    check_eq("ld7_value", 64'(rd_data_a), 64'h55);
    check_eq("ld7_count", 64'(busy_count), 64'd0);

    wb_en = 1; wb_addr = 3; wb_data = 32'hA;
    ld_en = 1; ld_addr = 3; ld_data = 32'hB;
    rd_addr_b = 3;
    step();
    check_eq("conflict_pulse", 64'(wr_conflict), 64'd1);
    idle(); rd_addr_a = 3;
    step();
    check_eq("reg3_wb_wins", 64'(rd_data_a), 64'hA);
    check_eq("conflict_drop", 64'(wr_conflict), 64'd0);

    claim_en = 1; claim_addr = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    rd_addr_a = 9;
    step();
    idle(); rd_addr_a = 9;
    step();
    check_eq("reg9_busy", 64'(rd_busy_a), 64'd1);
    check_eq("reg9_value", 64'(rd_data_a), 64'h99);

    claim_en = 1; claim_addr = 4;
    step();
    idle(); rd_addr_a = 4; rd_addr_b = 9;
    reset = 1'b1;
    #2;
    model_reset();
    check_eq("midreset_count", 64'(busy_count), 64'd0);
    check_eq("midreset_stall", 64'(stall), 64'd0);
    reset = 1'b0;
    step();

    wb_en = 1; wb_addr = 12; wb_data = 32'h1234; rd_addr_b = 12; rd_addr_a = 0;
    #1;
`ifdef RF_BYPASS_EN
    check_eq("bypass_b12", 64'(rd_data_b), 64'h1234);
`else
    check_eq("nobypass_b12", 64'(rd_data_b), 64'h0);
`endif
    step();
    idle();

    for (int n = 0; n < 300; n++) begin
      rd_addr_a  = 5'($urandom_range(0, 15));
      rd_addr_b  = 5'($urandom_range(0, 15));
      wb_en      = 1'($urandom_range(0, 1));
      wb_addr    = 5'($urandom_range(0, 15));
      wb_data    = $urandom;
      ld_en      = 1'($urandom_range(0, 1));
      ld_addr    = 5'($urandom_range(0, 15));
      ld_data    = $urandom;
      claim_en   = ($urandom_range(0, 3) != 0);
      claim_addr = 5'($urandom_range(0, 15));
      step();
    end
    idle();

    if (sb_q.size() != 0) check_eq("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
